// File: rtl/byte_mix_columns_serial_if.sv
// Byte-serial MixColumns stage bus: upstream byte stream in, transformed byte stream out.
interface byte_mix_columns_serial_if;
  logic [7:0] data_in;
  logic       in_valid;
  logic       mode;
  logic       bypass;
  logic [7:0] data_out;
  logic       out_valid;
  logic       block_done;

  modport master (
    output data_in, in_valid, mode, bypass,
    input  data_out, out_valid, block_done
  );

  modport slave (
    input  data_in, in_valid, mode, bypass,
    output data_out, out_valid, block_done
  );
endinterface

// File: rtl/byte_mix_columns_serial.sv
// Byte-serial AES MixColumns / InvMixColumns stage with column double buffering.
// Optional feature macro: MIX_COLUMNS_INV_EN (compiles in InvMixColumns; mode selects direction).
module byte_mix_columns_serial (
  input  logic                       clk,
  input  logic                       rst,
  byte_mix_columns_serial_if.slave   bus
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned BLK_W  = 4;

  logic [IDX_W-1:0]  byte_idx;
  logic [IDX_W-1:0]  col_idx;
  logic [BYTE_W-1:0] cap [4];
  logic              blk_mode;
  logic              blk_bypass;

  logic [BYTE_W-1:0] out_sr [3];
  logic [CNT_W-1:0]  out_cnt;
  logic [BLK_W-1:0]  out_blk;

  logic              col_load_c;
  logic              blk_start_c;
  logic              emit_c;
  logic [BYTE_W-1:0] col_a_c [4];
  logic [BYTE_W-1:0] col_b_c [4];

  // GF(2^8) doubling modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] x);
    xtime = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul3(input logic [7:0] x);
    mul3 = xtime(x) ^ x;
  endfunction

`ifdef MIX_COLUMNS_INV_EN
  function automatic logic [7:0] mul9(input logic [7:0] x);
    mul9 = xtime(xtime(xtime(x))) ^ x;
  endfunction

  function automatic logic [7:0] mulb(input logic [7:0] x);
    mulb = xtime(xtime(xtime(x))) ^ xtime(x) ^ x;
  endfunction

  function automatic logic [7:0] muld(input logic [7:0] x);
    muld = xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ x;
  endfunction

  function automatic logic [7:0] mule(input logic [7:0] x);
    mule = xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ xtime(x);
  endfunction
`endif

  assign col_load_c  = bus.in_valid && (byte_idx == IDX_W'(3));
  assign blk_start_c = bus.in_valid && (byte_idx == IDX_W'(0)) && (col_idx == IDX_W'(0));
  assign emit_c      = col_load_c || (out_cnt > CNT_W'(1));

  // Fourth byte bypasses the capture register so the column transforms on arrival
  always_comb begin
    col_a_c[0] = cap[1];
    col_a_c[1] = cap[2];
    col_a_c[2] = cap[3];
    col_a_c[3] = bus.data_in;
  end

  // Column transform: forward, inverse or pass-through, chosen per block
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      col_b_c[r] = xtime(col_a_c[r]) ^ mul3(col_a_c[(r + 1) % 4])
                 ^ col_a_c[(r + 2) % 4] ^ col_a_c[(r + 3) % 4];
`ifdef MIX_COLUMNS_INV_EN
      if (blk_mode) begin
        col_b_c[r] = mule(col_a_c[r]) ^ mulb(col_a_c[(r + 1) % 4])
                   ^ muld(col_a_c[(r + 2) % 4]) ^ mul9(col_a_c[(r + 3) % 4]);
      end
`endif
      if (blk_bypass) begin
        col_b_c[r] = col_a_c[r];
      end
    end
  end

  // Input side: byte/column indices, capture shift register, per-block mode latch
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_idx   <= '0;
      col_idx    <= '0;
      blk_mode   <= 1'b0;
      blk_bypass <= 1'b0;
      for (int i = 0; i < 4; i++) cap[i] <= '0;
    end else if (bus.in_valid) begin
      byte_idx <= byte_idx + IDX_W'(1);
      if (byte_idx == IDX_W'(3)) col_idx <= col_idx + IDX_W'(1);
      cap[0] <= cap[1];
      cap[1] <= cap[2];
      cap[2] <= cap[3];
      cap[3] <= bus.data_in;
      if (blk_start_c) begin
`ifdef MIX_COLUMNS_INV_EN
        blk_mode <= bus.mode;
`else
        blk_mode <= 1'b0;
`endif
        blk_bypass <= bus.bypass;
      end
    end
  end

`ifndef MIX_COLUMNS_INV_EN
  logic unused_mode;
  assign unused_mode = bus.mode;
`endif

  // Output side: a new column load overrides the tail of the previous one
  always_ff @(posedge clk) begin
    if (rst) begin
      out_cnt       <= '0;
      bus.data_out  <= '0;
      bus.out_valid <= 1'b0;
      for (int i = 0; i < 3; i++) out_sr[i] <= '0;
    end else if (col_load_c) begin
      out_cnt       <= CNT_W'(4);
      bus.data_out  <= col_b_c[0];
      bus.out_valid <= 1'b1;
      out_sr[0]     <= col_b_c[1];
      out_sr[1]     <= col_b_c[2];
      out_sr[2]     <= col_b_c[3];
    end else if (out_cnt > CNT_W'(1)) begin
      out_cnt       <= out_cnt - CNT_W'(1);
      bus.data_out  <= out_sr[0];
      bus.out_valid <= 1'b1;
      out_sr[0]     <= out_sr[1];
      out_sr[1]     <= out_sr[2];
      out_sr[2]     <= '0;
    end else begin
      out_cnt       <= '0;
      bus.data_out  <= '0;
      bus.out_valid <= 1'b0;
    end
  end

  // Output byte counter; block_done marks the 16th byte of each block
  always_ff @(posedge clk) begin
    if (rst) begin
      out_blk        <= '0;
      bus.block_done <= 1'b0;
    end else begin
      if (emit_c) out_blk <= out_blk + BLK_W'(1);
      bus.block_done <= emit_c && (out_blk == BLK_W'(15));
    end
  end

endmodule

// File: tb/tb_byte_mix_columns_serial.sv
// Directed bench for byte_mix_columns_serial (vector table plus multi-cycle sequences).
module tb_byte_mix_columns_serial;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   last_cyc;

  byte_mix_columns_serial_if bus ();

  byte_mix_columns_serial dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] din;
    logic        m;
    logic        bp;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [9];

  logic [7:0] out_q [$];
  int         cyc_q [$];
  logic       done_q [$];
  logic [7:0] exp_q [$];

  // Record every valid output byte with its cycle stamp
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      out_q.push_back(bus.data_out);
      cyc_q.push_back(cyc);
      done_q.push_back(bus.block_done);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    bus.data_in  = b;
    bus.in_valid = 1'b1;
    last_cyc     = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    bus.data_in  = 8'h00;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.data_in  = 8'h00;
    bus.mode     = 1'b0;
    bus.bypass   = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset data_out", 32'(bus.data_out), 32'd0);
    chk("reset block_done", 32'(bus.block_done), 32'd0);
    rst = 1'b0;
    out_q.delete();
    cyc_q.delete();
    done_q.delete();
    exp_q.delete();
  endtask

  // Compare collected output against exp_q: count, data, contiguous timing, block_done
  task automatic check_stream(input string name, input int exp_first);
    int n;
    chk({name, " count"}, 32'(out_q.size()), 32'(exp_q.size()));
    n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s byte%0d", name, i), 32'(out_q[i]), 32'(exp_q[i]));
      chk($sformatf("%s cyc%0d", name, i), 32'(cyc_q[i]), 32'(exp_first + i));
      chk($sformatf("%s done%0d", name, i), 32'(done_q[i]), 32'(((i + 1) % 16) == 0));
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    exp_q.push_back(w[31:24]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  initial begin
    int s;
    logic [31:0] w;

    vt[0] = '{32'hdb135345, 1'b0, 1'b0, 32'h8e4da1bc};
    vt[1] = '{32'hf20a225c, 1'b0, 1'b0, 32'h9fdc589d};
    vt[2] = '{32'h01010101, 1'b0, 1'b0, 32'h01010101};
    vt[3] = '{32'hc6c6c6c6, 1'b0, 1'b0, 32'hc6c6c6c6};
    vt[4] = '{32'hd4d4d4d5, 1'b0, 1'b0, 32'hd5d5d7d6};
    vt[5] = '{32'h2d26314c, 1'b0, 1'b0, 32'h4d7ebdf8};
    vt[6] = '{32'h12345678, 1'b1, 1'b1, 32'h12345678};
`ifdef MIX_COLUMNS_INV_EN
    vt[7] = '{32'h8e4da1bc, 1'b1, 1'b0, 32'hdb135345};
    vt[8] = '{32'hd5d5d7d6, 1'b1, 1'b0, 32'hd4d4d4d5};
`else
    vt[7] = '{32'hdb135345, 1'b1, 1'b0, 32'h8e4da1bc};
    vt[8] = '{32'hf20a225c, 1'b1, 1'b0, 32'h9fdc589d};
`endif

    bus.in_valid = 1'b0;
    bus.data_in  = 8'h00;
    bus.mode     = 1'b0;
    bus.bypass   = 1'b0;
    rst          = 1'b1;
    @(posedge clk);
    #1;

    // Single-column vectors, each at the start of a fresh block
    for (int v = 0; v < 9; v++) begin
      do_reset();
      bus.mode   = vt[v].m;
      bus.bypass = vt[v].bp;
      w = vt[v].din;
      send(w[31:24]);
      s = last_cyc;
      send(w[23:16]);
      send(w[15:8]);
      send(w[7:0]);
      idle(8);
      push_word(vt[v].exp);
      check_stream($sformatf("vec%0d", v), s + 4);
    end

    // Bypass block: identity, contiguous 16 bytes, block_done on the last
    do_reset();
    bus.bypass = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send(8'(i));
      if (i == 0) s = last_cyc;
      exp_q.push_back(8'(i));
    end
    idle(8);
    check_stream("bypass", s + 4);

    // Gapped input: output starts the cycle after the 4th byte
    do_reset();
    send(8'hdb);
    send(8'h13);
    idle(2);
    send(8'h53);
    idle(1);
    send(8'h45);
    s = last_cyc;
    idle(8);
    push_word(32'h8e4da1bc);
    check_stream("gapped", s + 1);

    // Mid-block mode/bypass change takes effect only at the next block
    do_reset();
    for (int i = 0; i < 16; i++) begin
      case (i % 4)
        0: send(8'hdb);
        1: send(8'h13);
        2: send(8'h53);
        default: send(8'h45);
      endcase
      if (i == 0) s = last_cyc;
      if (i == 5) begin
        bus.mode   = 1'b1;
        bus.bypass = 1'b1;
      end
    end
    for (int i = 0; i < 16; i++) send(8'(8'h40 + i));
    idle(8);
    for (int c = 0; c < 4; c++) push_word(32'h8e4da1bc);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'h40 + i));
    check_stream("midblock", s + 4);

    // Reset mid-column with output pending: nothing stale afterwards
    do_reset();
    send(8'hdb);
    send(8'h13);
    send(8'h53);
    send(8'h45);
    send(8'h77);
    send(8'h88);
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("in-reset out_valid%0d", k), 32'(bus.out_valid), 32'd0);
    end
    rst = 1'b0;
    out_q.delete();
    cyc_q.delete();
    done_q.delete();
    exp_q.delete();
    send(8'h01);
    s = last_cyc;
    send(8'h01);
    send(8'h01);
    send(8'h01);
    idle(8);
    push_word(32'h01010101);
    check_stream("rst_mid", s + 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
